// File: rtl/rim_pkg.sv
// Shared constants, error codes and FSM states for the rat-in-maze source/checker.
// Coordinates are 3 bits on the wire and are widened to 4 bits for arithmetic.
package rim_pkg;

   localparam int MAZE_DIM = 8;
   localparam int PATH_LEN = 15;

   localparam logic [2:0] ERR_NONE    = 3'd0;
   localparam logic [2:0] ERR_START   = 3'd1;
   localparam logic [2:0] ERR_STEP    = 3'd2;
   localparam logic [2:0] ERR_WALL    = 3'd3;
   localparam logic [2:0] ERR_GAP     = 3'd4;
   localparam logic [2:0] ERR_TIMEOUT = 3'd5;
   localparam logic [2:0] ERR_EXTRA   = 3'd6;

   localparam logic [3:0] IDX_NONE = 4'd15;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SEND,
      ST_WAIT,
      ST_RECV,
      ST_TAIL,
      ST_DONE
   } rim_state_e;

endpackage

// File: rtl/rim_maze_src_chk_if.sv
// Row-beat stream toward the solver and path-beat stream back from it.
// No backpressure: both directions are valid-only, one beat per cycle.
interface rim_maze_src_chk_if;
   logic       in_valid;
   logic [7:0] maze;
   logic       out_valid;
   logic [2:0] out_row;
   logic [2:0] out_col;

   modport master (output in_valid, maze, input out_valid, out_row, out_col);
   modport slave  (input in_valid, maze, output out_valid, out_row, out_col);
endinterface

// File: rtl/rim_step_check.sv
// Combinational legality check of one path beat against the previous beat.
// Zero latency; priority START > STEP > WALL.
module rim_step_check
   import rim_pkg::*;
(
   input  logic [2:0] i_prev_row,
   input  logic [2:0] i_prev_col,
   input  logic [2:0] i_cur_row,
   input  logic [2:0] i_cur_col,
   input  logic [3:0] i_beat,
   input  logic       i_cell,
   output logic [2:0] o_err
);

   logic [3:0] w_prev_row_inc;
   logic [3:0] w_prev_col_inc;
   logic       w_row_step;
   logic       w_col_step;

   // 4-bit compare so that a move off the edge (7+1) can never alias to 0
   assign w_prev_row_inc = {1'b0, i_prev_row} + 4'd1;
   assign w_prev_col_inc = {1'b0, i_prev_col} + 4'd1;
   assign w_row_step = ({1'b0, i_cur_row} == w_prev_row_inc) && (i_cur_col == i_prev_col);
   assign w_col_step = ({1'b0, i_cur_col} == w_prev_col_inc) && (i_cur_row == i_prev_row);

   always_comb begin
      o_err = ERR_NONE;
      if (i_beat == 4'd0) begin
         if (i_cur_row != 3'd0 || i_cur_col != 3'd0) begin
            o_err = ERR_START;
         end
      end else if (!(w_row_step || w_col_step)) begin
         o_err = ERR_STEP;
      end
      if (o_err == ERR_NONE && !i_cell) begin
         o_err = ERR_WALL;
      end
   end

endmodule

// File: rtl/rim_maze_src_chk.sv
// Maze store + sender (8 row beats) and checker of the 15-beat path reply; verdict pulse on done.
// Optional RIM_CHK_LATENCY_EN exposes send-to-first-beat latency; no backpressure on either stream.
module rim_maze_src_chk
   import rim_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int TO_W           = 11
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            cfg_we,
   input  logic [2:0]      cfg_row,
   input  logic [7:0]      cfg_data,
   input  logic            start,
   rim_maze_src_chk_if.master bus,
   output logic            busy,
   output logic            done,
   output logic            pass,
   output logic [2:0]      err_code,
   output logic [3:0]      err_idx,
   output logic [TO_W-1:0] latency
);

   rim_state_e      r_state;
   logic [7:0]      r_store [MAZE_DIM];
   logic [2:0]      r_k;
   logic [3:0]      r_b;
   logic [TO_W-1:0] r_cnt;
   logic [2:0]      r_prev_row;
   logic [2:0]      r_prev_col;
   logic            r_in_valid;
   logic [7:0]      r_maze;
   logic            r_busy;
   logic            r_done;
   logic            r_pass;
   logic [2:0]      r_err;
   logic [3:0]      r_idx;

   logic [7:0]      w_row_bits;
   logic            w_cell;
   logic [2:0]      w_chk;
   logic            w_latch;

   assign w_row_bits = r_store[bus.out_row];
   assign w_cell     = w_row_bits[bus.out_col];
   assign w_latch    = (r_err == ERR_NONE) && (w_chk != ERR_NONE);

   rim_step_check u_step (
      .i_prev_row (r_prev_row),
      .i_prev_col (r_prev_col),
      .i_cur_row  (bus.out_row),
      .i_cur_col  (bus.out_col),
      .i_beat     (r_b),
      .i_cell     (w_cell),
      .o_err      (w_chk)
   );

`ifdef RIM_CHK_LATENCY_EN
   logic [TO_W-1:0] r_lat;
   assign latency = r_lat;
`else
   assign latency = '0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         for (int i = 0; i < MAZE_DIM; i++) r_store[i] <= '0;
         r_k        <= '0;
         r_b        <= '0;
         r_cnt      <= '0;
         r_prev_row <= '0;
         r_prev_col <= '0;
         r_in_valid <= 1'b0;
         r_maze     <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_pass     <= 1'b0;
         r_err      <= ERR_NONE;
         r_idx      <= '0;
`ifdef RIM_CHK_LATENCY_EN
         r_lat      <= '0;
`endif
      end else begin
         if (cfg_we && !r_busy) r_store[cfg_row] <= cfg_data;

         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_state    <= ST_SEND;
                  r_busy     <= 1'b1;
                  r_err      <= ERR_NONE;
                  r_idx      <= '0;
                  r_pass     <= 1'b0;
                  r_b        <= '0;
                  r_k        <= '0;
                  r_in_valid <= 1'b1;
                  r_maze     <= r_store[0];
`ifdef RIM_CHK_LATENCY_EN
                  r_lat      <= '0;
`endif
               end
            end
            ST_SEND: begin
               if (r_k == 3'(MAZE_DIM - 1)) begin
                  r_state    <= ST_WAIT;
                  r_in_valid <= 1'b0;
                  r_maze     <= '0;
                  r_cnt      <= TO_W'(1);
               end else begin
                  r_k    <= r_k + 3'd1;
                  r_maze <= r_store[r_k + 3'd1];
               end
            end
            ST_WAIT: begin
               // The first reply beat is checked in this very cycle as beat 0
               if (bus.out_valid) begin
                  if (w_latch) begin
                     r_err <= w_chk;
                     r_idx <= r_b;
                  end
                  r_prev_row <= bus.out_row;
                  r_prev_col <= bus.out_col;
                  r_b        <= 4'd1;
                  r_state    <= ST_RECV;
`ifdef RIM_CHK_LATENCY_EN
                  r_lat      <= r_cnt;
`endif
               end else if (r_cnt == TO_W'(TIMEOUT_CYCLES)) begin
                  r_err   <= ERR_TIMEOUT;
                  r_idx   <= IDX_NONE;
                  r_pass  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= ST_DONE;
               end else if (r_cnt != '1) begin
                  r_cnt <= r_cnt + TO_W'(1);
               end
            end
            ST_RECV: begin
               if (bus.out_valid) begin
                  if (w_latch) begin
                     r_err <= w_chk;
                     r_idx <= r_b;
                  end
                  r_prev_row <= bus.out_row;
                  r_prev_col <= bus.out_col;
                  if (r_b == 4'(PATH_LEN - 1)) r_state <= ST_TAIL;
                  else                         r_b     <= r_b + 4'd1;
               end else begin
                  if (r_err == ERR_NONE) begin
                     r_err <= ERR_GAP;
                     r_idx <= IDX_NONE;
                  end
                  r_pass  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= ST_DONE;
               end
            end
            ST_TAIL: begin
               if (bus.out_valid && r_err == ERR_NONE) begin
                  r_err <= ERR_EXTRA;
                  r_idx <= IDX_NONE;
               end
               r_pass  <= (r_err == ERR_NONE) && !bus.out_valid;
               r_done  <= 1'b1;
               r_state <= ST_DONE;
            end
            ST_DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.in_valid = r_in_valid;
   assign bus.maze     = r_maze;
   assign busy         = r_busy;
   assign done         = r_done;
   assign pass         = r_pass;
   assign err_code     = r_err;
   assign err_idx      = r_idx;

endmodule

// File: tb/tb_rim_maze_src_chk.sv
// Directed bench for rim_maze_src_chk: hand-built mazes and path replies with expected verdicts.
module tb_rim_maze_src_chk;

   localparam int TO   = 16;
   localparam int TO_W = 11;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            cfg_we = 1'b0;
   logic [2:0]      cfg_row = '0;
   logic [7:0]      cfg_data = '0;
   logic            start = 1'b0;
   logic            busy, done, pass;
   logic [2:0]      err_code;
   logic [3:0]      err_idx;
   logic [TO_W-1:0] latency;

   rim_maze_src_chk_if bus ();

   rim_maze_src_chk #(.TIMEOUT_CYCLES(TO), .TO_W(TO_W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .cfg_we   (cfg_we),
      .cfg_row  (cfg_row),
      .cfg_data (cfg_data),
      .start    (start),
      .bus      (bus),
      .busy     (busy),
      .done     (done),
      .pass     (pass),
      .err_code (err_code),
      .err_idx  (err_idx),
      .latency  (latency)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   logic [2:0] p_row [16];
   logic [2:0] p_col [16];
   int         n_beats;

   logic [7:0] obs_rows [8];
   int         obs_vld_cnt;
   logic       obs_vld_after;
   logic [7:0] obs_maze_after;
   int         obs_wait;
   logic       obs_done_seen;
   logic       obs_pass;
   logic [2:0] obs_err;
   logic [3:0] obs_idx;
   logic       obs_busy_at_done;
   logic       obs_busy_after;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_row(input logic [2:0] r, input logic [7:0] d);
      cfg_we = 1'b1; cfg_row = r; cfg_data = d;
      tick();
      cfg_we = 1'b0;
   endtask

   task automatic set_main_path();
      for (int i = 0; i < 8; i++) begin p_row[i] = 3'(i); p_col[i] = 3'd0; end
      for (int i = 8; i < 15; i++) begin p_row[i] = 3'd7; p_col[i] = 3'(i - 7); end
      p_row[15] = 3'd7; p_col[15] = 3'd7;
      n_beats = 15;
   endtask

   // Start a run, record the 8 row beats, play n_beats path beats, then wait for done.
   task automatic run_path();
      obs_vld_cnt = 0;
      start = 1'b1;
      for (int k = 0; k < 8; k++) begin
         tick();
         start = 1'b0;
         obs_rows[k] = bus.maze;
         if (bus.in_valid) obs_vld_cnt++;
      end
      tick();
      obs_vld_after  = bus.in_valid;
      obs_maze_after = bus.maze;
      for (int i = 0; i < n_beats; i++) begin
         bus.out_valid = 1'b1; bus.out_row = p_row[i]; bus.out_col = p_col[i];
         tick();
      end
      bus.out_valid = 1'b0; bus.out_row = '0; bus.out_col = '0;
      obs_wait = 0;
      obs_done_seen = 1'b0;
      while (obs_wait < 200) begin
         if (done) begin
            obs_done_seen = 1'b1;
            obs_pass = pass; obs_err = err_code; obs_idx = err_idx;
            obs_busy_at_done = busy;
            break;
         end
         tick();
         obs_wait++;
      end
      tick();
      obs_busy_after = busy;
   endtask

   task automatic test_reset();
      checks++; if (bus.in_valid !== 1'b0) begin errors++; $display("FAIL reset_in_valid: got %b want 0", bus.in_valid); end
      checks++; if (bus.maze !== 8'h00) begin errors++; $display("FAIL reset_maze: got %h want 00", bus.maze); end
      checks++; if ({busy, done, pass} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {busy, done, pass}); end
      checks++; if ({err_code, err_idx} !== 7'd0) begin errors++; $display("FAIL reset_err: got %h/%h want 0/0", err_code, err_idx); end
      checks++; if (latency !== '0) begin errors++; $display("FAIL reset_latency: got %0d want 0", latency); end
      // cleared store: every row reads 0 and beat 0 hits a wall
      set_main_path();
      run_path();
      for (int k = 0; k < 8; k++) begin
         checks++; if (obs_rows[k] !== 8'h00) begin errors++; $display("FAIL reset_store_row%0d: got %h want 00", k, obs_rows[k]); end
      end
      checks++; if (!obs_done_seen) begin errors++; $display("FAIL reset_run_done: got none want pulse"); end
      checks++; if ({obs_err, obs_idx} !== {3'd3, 4'd0}) begin errors++; $display("FAIL reset_run_err: got %0d/%0d want 3/0", obs_err, obs_idx); end
   endtask

   task automatic test_reset_abort();
      logic seen;
      start = 1'b1; tick(); start = 1'b0;
      tick(); tick();
      rst_n = 1'b0; #2;
      checks++; if ({busy, bus.in_valid} !== 2'b00) begin errors++; $display("FAIL abort_clear: got %b want 00", {busy, bus.in_valid}); end
      tick(); rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin tick(); if (done) seen = 1'b1; end
      checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_no_done: got done=%b want 0", seen); end
   endtask

   task automatic test_pass();
      logic [7:0] exp_rows [8];
      exp_rows[0] = 8'h81; exp_rows[1] = 8'h03; exp_rows[2] = 8'h05; exp_rows[3] = 8'h09;
      exp_rows[4] = 8'h11; exp_rows[5] = 8'h21; exp_rows[6] = 8'h41; exp_rows[7] = 8'hFF;
      for (int k = 0; k < 8; k++) write_row(3'(k), exp_rows[k]);
      set_main_path();
      run_path();
      for (int k = 0; k < 8; k++) begin
         checks++; if (obs_rows[k] !== exp_rows[k]) begin errors++; $display("FAIL pass_row%0d: got %h want %h", k, obs_rows[k], exp_rows[k]); end
      end
      checks++; if (obs_vld_cnt !== 8) begin errors++; $display("FAIL pass_in_valid_cnt: got %0d want 8", obs_vld_cnt); end
      checks++; if ({obs_vld_after, obs_maze_after} !== 9'd0) begin errors++; $display("FAIL pass_after_send: got %b/%h want 0/00", obs_vld_after, obs_maze_after); end
      checks++; if (!obs_done_seen || obs_wait !== 1) begin errors++; $display("FAIL pass_done_time: got seen=%b wait=%0d want 1/1", obs_done_seen, obs_wait); end
      checks++; if ({obs_pass, obs_err} !== {1'b1, 3'd0}) begin errors++; $display("FAIL pass_verdict: got pass=%b err=%0d want 1/0", obs_pass, obs_err); end
      checks++; if ({obs_busy_at_done, obs_busy_after} !== 2'b10) begin errors++; $display("FAIL pass_busy: got %b want 10", {obs_busy_at_done, obs_busy_after}); end
   endtask

   task automatic test_step();
      for (int k = 0; k < 8; k++) write_row(3'(k), 8'hFF);
      p_row[0] = 3'd0; p_col[0] = 3'd0;
      for (int i = 1; i < 5; i++) begin p_row[i] = 3'(i); p_col[i] = 3'd0; end
      p_row[5] = 3'd5; p_col[5] = 3'd1;
      p_row[6] = 3'd6; p_col[6] = 3'd1;
      p_row[7] = 3'd7; p_col[7] = 3'd1;
      for (int i = 8; i < 14; i++) begin p_row[i] = 3'd7; p_col[i] = 3'(i - 6); end
      p_row[14] = 3'd7; p_col[14] = 3'd7;
      n_beats = 15;
      run_path();
      checks++; if (!obs_done_seen || obs_wait !== 1) begin errors++; $display("FAIL step_done_time: got seen=%b wait=%0d want 1/1", obs_done_seen, obs_wait); end
      checks++; if ({obs_pass, obs_err, obs_idx} !== {1'b0, 3'd2, 4'd5}) begin errors++; $display("FAIL step_err: got pass=%b err=%0d idx=%0d want 0/2/5", obs_pass, obs_err, obs_idx); end
   endtask

   task automatic test_wall();
      write_row(3'd3, 8'hFE);
      set_main_path();
      run_path();
      checks++; if (obs_rows[3] !== 8'hFE) begin errors++; $display("FAIL wall_row3: got %h want fe", obs_rows[3]); end
      checks++; if ({obs_pass, obs_err, obs_idx} !== {1'b0, 3'd3, 4'd3}) begin errors++; $display("FAIL wall_err: got pass=%b err=%0d idx=%0d want 0/3/3", obs_pass, obs_err, obs_idx); end
      write_row(3'd3, 8'hFF);
   endtask

   task automatic test_start_first();
      set_main_path();
      p_col[0] = 3'd1;
      p_row[6] = 3'd0; p_col[6] = 3'd0;
      run_path();
      checks++; if ({obs_pass, obs_err, obs_idx} !== {1'b0, 3'd1, 4'd0}) begin errors++; $display("FAIL start_err: got pass=%b err=%0d idx=%0d want 0/1/0", obs_pass, obs_err, obs_idx); end
   endtask

   task automatic test_timeout();
      n_beats = 0;
      run_path();
      checks++; if (!obs_done_seen || obs_wait !== TO) begin errors++; $display("FAIL timeout_time: got seen=%b wait=%0d want 1/%0d", obs_done_seen, obs_wait, TO); end
      checks++; if ({obs_pass, obs_err, obs_idx} !== {1'b0, 3'd5, 4'd15}) begin errors++; $display("FAIL timeout_err: got pass=%b err=%0d idx=%0d want 0/5/15", obs_pass, obs_err, obs_idx); end
   endtask

   task automatic test_gap();
      set_main_path();
      n_beats = 10;
      run_path();
      checks++; if (!obs_done_seen || obs_wait !== 1) begin errors++; $display("FAIL gap_done_time: got seen=%b wait=%0d want 1/1", obs_done_seen, obs_wait); end
      checks++; if ({obs_pass, obs_err, obs_idx} !== {1'b0, 3'd4, 4'd15}) begin errors++; $display("FAIL gap_err: got pass=%b err=%0d idx=%0d want 0/4/15", obs_pass, obs_err, obs_idx); end
   endtask

   task automatic test_extra();
      set_main_path();
      n_beats = 16;
      run_path();
      checks++; if (!obs_done_seen || obs_wait !== 0) begin errors++; $display("FAIL extra_done_time: got seen=%b wait=%0d want 1/0", obs_done_seen, obs_wait); end
      checks++; if ({obs_pass, obs_err, obs_idx} !== {1'b0, 3'd6, 4'd15}) begin errors++; $display("FAIL extra_err: got pass=%b err=%0d idx=%0d want 0/6/15", obs_pass, obs_err, obs_idx); end
   endtask

   task automatic test_cfg_busy();
      int w;
      start = 1'b1; tick(); start = 1'b0;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL cfgbusy_busy: got %b want 1", busy); end
      write_row(3'd2, 8'h00);
      w = 0;
      while (!done && w < 100) begin tick(); w++; end
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL cfgbusy_done: got %b want 1", done); end
      tick();
      start = 1'b1; tick(); start = 1'b0;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL cfgbusy_restart: got %b want 1", busy); end
      w = 0;
      while (!done && w < 100) begin tick(); w++; end
      tick();
      set_main_path();
      run_path();
      checks++; if (obs_rows[2] !== 8'hFF) begin errors++; $display("FAIL cfgbusy_row2: got %h want ff", obs_rows[2]); end
      checks++; if ({obs_pass, obs_err} !== {1'b1, 3'd0}) begin errors++; $display("FAIL cfgbusy_verdict: got pass=%b err=%0d want 1/0", obs_pass, obs_err); end
   endtask

   initial begin
      bus.out_valid = 1'b0; bus.out_row = '0; bus.out_col = '0;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      test_reset();
      test_reset_abort();
      test_pass();
      test_step();
      test_wall();
      test_start_first();
      test_timeout();
      test_gap();
      test_extra();
      test_cfg_busy();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/rim_maze_src_chk.md
Name: rim_maze_src_chk

Overview:
- Maze-side counterpart of the rat-in-maze solver.
- Holds an 8x8 maze written by a host and streams it to the solver as 8 row beats (in_valid/maze).
- Then consumes the solver's 15-beat path response (out_valid/out_row/out_col) and checks legality.
- Reports pass/fail, first error code and beat index; used for on-chip self-test and as the bench-side driver.

Parameters:
- TIMEOUT_CYCLES, 1024, max cycles in WAIT for first out_valid before timeout error.
- TO_W, 11, width of timeout/latency counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- cfg_we  in  1  host write strobe for one maze row
- cfg_row  in  3  row address for cfg_we
- cfg_data  in  8  row bits; bit c = column c; 1 = open, 0 = wall
- start  in  1  single-cycle pulse; begins send+check
- in_valid  out  1  row beat valid toward solver
- maze  out  8  row data toward solver, row 0 first
- out_valid  in  1  path beat valid from solver
- out_row  in  3  path row
- out_col  in  3  path column
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse when verdict is final
- pass  out  1  verdict, valid from done until next start
- err_code  out  3  first error code
- err_idx  out  4  beat index (0..14) of first error; 15 for TIMEOUT, GAP or EXTRA
- latency  out  TO_W  cycles from last row beat to first path beat (optional feature)

Behaviour:
- Reset: all outputs 0; maze store cleared to 0; FSM = IDLE.
- Reset mid-operation aborts with no done pulse.
- Maze store:
  - 8x8 bits.
  - cfg_we writes row cfg_row on the clock edge, only when busy=0; ignored while busy.
- FSM states:
  - IDLE: start=1 -> SEND; clears err_code, err_idx, pass, beat counter. start while busy is ignored.
  - SEND: 8 consecutive cycles. in_valid=1, maze=row k, k=0..7 (registered outputs). After row 7 -> WAIT; in_valid=0, maze=0 the cycle after.
  - WAIT: counts cycles.
    - out_valid=1 -> RECV, and that cycle is beat 0.
    - Count reaches TIMEOUT_CYCLES -> DONE with err TIMEOUT.
    - out_valid coinciding with the final SEND cycle is not possible by protocol; ignored.
  - RECV: beat counter b=0..14, one beat per out_valid cycle.
    - out_valid=0 before b=15 -> DONE with GAP.
    - After beat 14 -> TAIL.
  - TAIL: one cycle. out_valid=1 -> EXTRA; then DONE.
  - DONE: one cycle. done=1, pass=(err_code==0), busy=0 next; -> IDLE.
- Beat checks (compare against the previous accepted beat, registered):
  - b=0 must be (0,0), else START.
  - b>0 must be prev+(1,0) or prev+(0,1), else STEP.
  - Every beat's cell must be open in the store, else WALL.
  - 14 monotone unit steps from (0,0) imply b=14 is (7,7); no separate end check.
- Only the first error is latched (code + index); later errors are ignored. Beats continue to be consumed until b=15 or GAP.
- Simultaneous errors on one beat: priority START > STEP > WALL.
- Error codes: 0 NONE, 1 START, 2 STEP, 3 WALL, 4 GAP, 5 TIMEOUT, 6 EXTRA.
- Coordinate arithmetic is done in 4 bits so that 7+1 does not wrap to 0 and falsely match.

Optional Feature:
- Macro RIM_CHK_LATENCY_EN.
- Defined: latency captures the WAIT counter value at the first out_valid beat. It holds until next start and saturates at all-ones.
- Undefined: latency tied to 0. The timeout counter still exists.

Decomposition:
- Package rim_pkg:
  - MAZE_DIM=8, PATH_LEN=15
  - error code constants
  - FSM state enum
- One sub-module, rim_step_check: purely combinational. Inputs: prev coordinate, cur coordinate, beat index, cell bit. Output: error code. The FSM, store and counters stay in the top.

Test Plan:
- All rows 0xFF, start; respond (0,0),(1,0)..(7,0),(7,1)..(7,7) on 15 consecutive cycles -> in_valid 8 cycles with maze=0xFF; done, pass=1, err_code=0.
- Same maze; beat 5 jumps (4,0)->(5,1) -> err_code=2, err_idx=5, pass=0; done still after beat 14.
- Row 3 = 0xFE; path includes (3,0) at beat 3 -> err_code=3, err_idx=3.
- Beat 0 = (0,1) and beat 6 also illegal -> err_code=1, err_idx=0 (first error kept).
- No out_valid after SEND, TIMEOUT_CYCLES=16 -> done 16 cycles after WAIT entry; err_code=5, err_idx=15.
- out_valid drops after beat 9 -> err_code=4; separate run with a 16th beat -> err_code=6; cfg_we during busy leaves the store unchanged (read back via the next send).
